// File: rtl/password_lock_n.sv
// password_lock_n: digit-sequence password lock with retry lockout
// Latency: every output is registered and reflects a confirm on the next rising edge.
// Backpressure: none; each confirm cycle is consumed or ignored, and a held confirm counts once per cycle.
//
// Optional feature macro: PASSWORD_PROGRAM_EN
//   If defined, the prog_req input and a PROGRAM state are added, so an
//   admitted user can replace the stored password. If undefined, the password
//   is fixed at PASSWORD.
//
// Ports:
//   clock       in   system clock; all state updates on the rising edge
//   rst         in   asynchronous, active-low reset
//   confirm     in   single-cycle digit-entry strobe (already debounced)
//   digit_in    in   [DW-1:0] digit sampled when confirm is high
//   prog_req    in   (PASSWORD_PROGRAM_EN only) confirm in ADMIT starts programming
//   admitted    out  high while in ADMIT (or PROGRAM)
//   locked      out  high while in LOCKOUT
//   progress    out  [3:0] digits accepted so far in the current sequence
//   entered     out  [DIGITS*DW-1:0] digits accepted so far, digit 0 in the low slot
//   fail_count  out  [7:0] consecutive failed sequences
module password_lock_n #(
  parameter int DIGITS       = 4,
  parameter int DW           = 4,
  parameter logic [DIGITS*DW-1:0] PASSWORD = 16'h4321,
  parameter int MAX_FAIL     = 3,
  parameter int ADMIT_CYCLES = 12,
  parameter int LOCK_CYCLES  = 1000
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 confirm,
  input  logic [DW-1:0]        digit_in,
`ifdef PASSWORD_PROGRAM_EN
  input  logic                 prog_req,
`endif
  output logic                 admitted,
  output logic                 locked,
  output logic [3:0]           progress,
  output logic [DIGITS*DW-1:0] entered,
  output logic [7:0]           fail_count
);

  localparam int SW = DIGITS * DW;

  // The dwell timer counts down from (cycles-1) to 0, so it only has to hold
  // the larger dwell minus one.
  localparam int DWELL_MAX = (ADMIT_CYCLES > LOCK_CYCLES) ? ADMIT_CYCLES : LOCK_CYCLES;
  localparam int CW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

  localparam logic [CW-1:0] ADMIT_LOAD = CW'(ADMIT_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    LAST_SLOT  = 4'(DIGITS - 1);
  localparam logic [7:0]    FAIL_LIMIT = 8'(MAX_FAIL);

`ifdef PASSWORD_PROGRAM_EN
  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_ADMIT   = 2'd1,
    S_LOCKOUT = 2'd2,
    S_PROGRAM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_ADMIT   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    progress_q, progress_d;
  logic [SW-1:0] entered_q, entered_d;
  logic [7:0]    fail_q, fail_d;
  logic          admitted_q, admitted_d;
  logic          locked_q, locked_d;

  // Working values shared by the next-state logic.
  logic [SW-1:0] filled;      // entered with the current digit written into its slot
  logic          last_digit;  // this confirm completes the sequence
  logic [7:0]    fail_inc;    // saturating fail_count + 1
  logic [SW-1:0] stored_pwd;

`ifdef PASSWORD_PROGRAM_EN
  logic [SW-1:0] pwd_q, pwd_d;
  assign stored_pwd = pwd_q;
`else
  assign stored_pwd = PASSWORD;
`endif

  always_comb begin
    filled = entered_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (progress_q == 4'(k)) begin
        filled[k*DW +: DW] = digit_in;
      end
    end
    last_digit = (progress_q == LAST_SLOT);
    fail_inc   = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    progress_d = progress_q;
    entered_d  = entered_q;
    fail_d     = fail_q;
`ifdef PASSWORD_PROGRAM_EN
    pwd_d      = pwd_q;
`endif

    case (state_q)
      S_ENTRY: begin
        if (confirm) begin
          if (last_digit) begin
            // Sequence complete: judge it, then start the next one afresh.
            progress_d = 4'd0;
            entered_d  = '0;
            if (filled == stored_pwd) begin
              state_d = S_ADMIT;
              timer_d = ADMIT_LOAD;
              fail_d  = 8'd0;
            end else if (fail_inc >= FAIL_LIMIT) begin
              state_d = S_LOCKOUT;
              timer_d = LOCK_LOAD;
              fail_d  = FAIL_LIMIT;
            end else begin
              fail_d = fail_inc;
            end
          end else begin
            entered_d  = filled;
            progress_d = progress_q + 4'd1;
          end
        end
      end

      S_ADMIT: begin
`ifdef PASSWORD_PROGRAM_EN
        // The digit on the request cycle only opens programming; it is not stored.
        if (confirm && prog_req) begin
          state_d    = S_PROGRAM;
          progress_d = 4'd0;
          entered_d  = '0;
        end else
`endif
        if (timer_q == '0) begin
          state_d = S_ENTRY;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end

      S_LOCKOUT: begin
        // Confirms are dropped for the whole lockout.
        if (timer_q == '0) begin
          state_d = S_ENTRY;
          fail_d  = 8'd0;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end

`ifdef PASSWORD_PROGRAM_EN
      S_PROGRAM: begin
        // No timeout here: the user stays admitted until the new code is complete.
        if (confirm) begin
          if (last_digit) begin
            pwd_d      = filled;
            state_d    = S_ENTRY;
            progress_d = 4'd0;
            entered_d  = '0;
          end else begin
            entered_d  = filled;
            progress_d = progress_q + 4'd1;
          end
        end
      end
`endif

      default: begin
        state_d    = S_ENTRY;
        progress_d = 4'd0;
        entered_d  = '0;
      end
    endcase

`ifdef PASSWORD_PROGRAM_EN
    admitted_d = (state_d == S_ADMIT) || (state_d == S_PROGRAM);
`else
    admitted_d = (state_d == S_ADMIT);
`endif
    locked_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= S_ENTRY;
      timer_q    <= '0;
      progress_q <= 4'd0;
      entered_q  <= '0;
      fail_q     <= 8'd0;
      admitted_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      progress_q <= progress_d;
      entered_q  <= entered_d;
      fail_q     <= fail_d;
      admitted_q <= admitted_d;
      locked_q   <= locked_d;
    end
  end

`ifdef PASSWORD_PROGRAM_EN
  // A reset abandons any reprogramming and restores the reset password.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pwd_q <= PASSWORD;
    end else begin
      pwd_q <= pwd_d;
    end
  end
`endif

  assign admitted   = admitted_q;
  assign locked     = locked_q;
  assign progress   = progress_q;
  assign entered    = entered_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_password_lock_n.sv
// tb_password_lock_n: directed bench for password_lock_n with the default parameters.
// Each step drives one cycle of input, queues the expected outputs and checks them after the edge.
// The program sequence is exercised only when PASSWORD_PROGRAM_EN is defined.
module tb_password_lock_n;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        confirm = 1'b0;
  logic [3:0]  digit_in = 4'd0;
`ifdef PASSWORD_PROGRAM_EN
  logic        prog_req = 1'b0;
`endif
  logic        admitted;
  logic        locked;
  logic [3:0]  progress;
  logic [15:0] entered;
  logic [7:0]  fail_count;

  password_lock_n #(
    .DIGITS(4), .DW(4), .PASSWORD(16'h4321), .MAX_FAIL(3),
    .ADMIT_CYCLES(12), .LOCK_CYCLES(1000)
  ) dut (
    .clock(clock),
    .rst(rst),
    .confirm(confirm),
    .digit_in(digit_in),
`ifdef PASSWORD_PROGRAM_EN
    .prog_req(prog_req),
`endif
    .admitted(admitted),
    .locked(locked),
    .progress(progress),
    .entered(entered),
    .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        adm;
    logic        lck;
    logic [3:0]  prg;
    logic [15:0] ent;
    logic [7:0]  fc;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic obs_t mk(input logic a, input logic l, input logic [3:0] p,
                              input logic [15:0] e, input logic [7:0] f);
    obs_t o;
    o.adm = a; o.lck = l; o.prg = p; o.ent = e; o.fc = f;
    return o;
  endfunction

  // Pop the oldest expectation and compare it with the live DUT outputs.
  task automatic compare_now();
    obs_t  obs;
    obs_t  exp;
    string tag;
    obs = mk(admitted, locked, progress, entered, fail_count);
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed adm=%0b lck=%0b prg=%0d ent=%h fc=%0d, expected adm=%0b lck=%0b prg=%0d ent=%h fc=%0d",
             tag, obs.adm, obs.lck, obs.prg, obs.ent, obs.fc,
             exp.adm, exp.lck, exp.prg, exp.ent, exp.fc);
    end
  endtask

  // Expectation for the current moment (no clock edge), e.g. asynchronous reset.
  task automatic expect_now(input obs_t exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    compare_now();
  endtask

  // Drive one cycle of input; outputs after the following rising edge must equal exp.
  task automatic step(input logic c, input logic [3:0] d, input obs_t exp, input string tag);
    confirm  = c;
    digit_in = d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    compare_now();
    confirm = 1'b0;
  endtask

  // Enter 1,2,3,4 starting from an empty ENTRY sequence with fail_count f.
  task automatic admit_seq(input logic [7:0] f);
    step(1'b1, 4'd1, mk(1'b0, 1'b0, 4'd1, 16'h0001, f), "good_d0");
    step(1'b1, 4'd2, mk(1'b0, 1'b0, 4'd2, 16'h0021, f), "good_d1");
    step(1'b1, 4'd3, mk(1'b0, 1'b0, 4'd3, 16'h0321, f), "good_d2");
    step(1'b1, 4'd4, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "good_admit");
  endtask

  // Remaining 11 admitted cycles, then back to ENTRY.
  task automatic admit_drain();
    for (int i = 2; i <= 12; i++) begin
      step(1'b0, 4'd0, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_hold");
    end
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_end");
  endtask

  // Enter 5,5,5,5 with fail_count f beforehand; the result is checked as fin.
  task automatic wrong_5555(input logic [7:0] f, input obs_t fin);
    step(1'b1, 4'd5, mk(1'b0, 1'b0, 4'd1, 16'h0005, f), "w5_d0");
    step(1'b1, 4'd5, mk(1'b0, 1'b0, 4'd2, 16'h0055, f), "w5_d1");
    step(1'b1, 4'd5, mk(1'b0, 1'b0, 4'd3, 16'h0555, f), "w5_d2");
    step(1'b1, 4'd5, fin, "w5_end");
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_now(mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "reset");
    rst = 1'b1;

    // Correct code admits for exactly 12 cycles; a confirm during ADMIT is ignored.
    admit_seq(8'd0);
    for (int i = 2; i <= 12; i++) begin
      step(i == 5, 4'd9, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_hold");
    end
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_end");

    // Wrong code 1,9,3,4: no early abort, one failure recorded.
    step(1'b1, 4'd1, mk(1'b0, 1'b0, 4'd1, 16'h0001, 8'd0), "w1934_d0");
    step(1'b1, 4'd9, mk(1'b0, 1'b0, 4'd2, 16'h0091, 8'd0), "w1934_d1");
    step(1'b1, 4'd3, mk(1'b0, 1'b0, 4'd3, 16'h0391, 8'd0), "w1934_d2");
    step(1'b1, 4'd4, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd1), "w1934_end");
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd1), "idle_keeps");

    // Second failure, then a reversed code as the third failure triggers lockout.
    wrong_5555(8'd1, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd2));
    step(1'b1, 4'd4, mk(1'b0, 1'b0, 4'd1, 16'h0004, 8'd2), "w4321_d0");
    step(1'b1, 4'd3, mk(1'b0, 1'b0, 4'd2, 16'h0034, 8'd2), "w4321_d1");
    step(1'b1, 4'd2, mk(1'b0, 1'b0, 4'd3, 16'h0234, 8'd2), "w4321_d2");
    step(1'b1, 4'd1, mk(1'b0, 1'b1, 4'd0, 16'h0000, 8'd3), "lock_enter");

    // Lockout lasts 1000 cycles with confirms held high the whole time.
    for (int i = 2; i <= 1000; i++) begin
      step(1'b1, 4'(i), mk(1'b0, 1'b1, 4'd0, 16'h0000, 8'd3), "lock_hold");
    end
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "lock_end");
    admit_seq(8'd0);
    admit_drain();

    // Reset after two correct digits discards them.
    step(1'b1, 4'd1, mk(1'b0, 1'b0, 4'd1, 16'h0001, 8'd0), "pre_rst_d0");
    step(1'b1, 4'd2, mk(1'b0, 1'b0, 4'd2, 16'h0021, 8'd0), "pre_rst_d1");
    rst = 1'b0;
    #1;
    expect_now(mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "rst_mid_seq");
    @(posedge clock);
    #1;
    rst = 1'b1;
    admit_seq(8'd0);

    // Reset during ADMIT drops it immediately and ADMIT does not resume.
    step(1'b0, 4'd0, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_pre_rst");
    rst = 1'b0;
    #1;
    expect_now(mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "rst_mid_admit");
    @(posedge clock);
    #1;
    rst = 1'b1;
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "admit_not_resumed");

    // Reset during LOCKOUT clears it; the correct code then admits at once.
    wrong_5555(8'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd1));
    wrong_5555(8'd1, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd2));
    wrong_5555(8'd2, mk(1'b0, 1'b1, 4'd0, 16'h0000, 8'd3));
    step(1'b0, 4'd0, mk(1'b0, 1'b1, 4'd0, 16'h0000, 8'd3), "lock2_hold");
    rst = 1'b0;
    #1;
    expect_now(mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "rst_mid_lock");
    @(posedge clock);
    #1;
    rst = 1'b1;
    step(1'b0, 4'd0, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "lock_not_resumed");
    admit_seq(8'd0);
    admit_drain();

`ifdef PASSWORD_PROGRAM_EN
    // Program 7,7,7,7 from ADMIT; the old code then fails and the new one admits.
    admit_seq(8'd0);
    prog_req = 1'b1;
    step(1'b1, 4'd9, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "prog_enter");
    prog_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'd0, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "prog_no_timeout");
    end
    step(1'b1, 4'd7, mk(1'b1, 1'b0, 4'd1, 16'h0007, 8'd0), "prog_d0");
    step(1'b1, 4'd7, mk(1'b1, 1'b0, 4'd2, 16'h0077, 8'd0), "prog_d1");
    step(1'b1, 4'd7, mk(1'b1, 1'b0, 4'd3, 16'h0777, 8'd0), "prog_d2");
    step(1'b1, 4'd7, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "prog_store");
    step(1'b1, 4'd1, mk(1'b0, 1'b0, 4'd1, 16'h0001, 8'd0), "old_d0");
    step(1'b1, 4'd2, mk(1'b0, 1'b0, 4'd2, 16'h0021, 8'd0), "old_d1");
    step(1'b1, 4'd3, mk(1'b0, 1'b0, 4'd3, 16'h0321, 8'd0), "old_d2");
    step(1'b1, 4'd4, mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd1), "old_rejected");
    step(1'b1, 4'd7, mk(1'b0, 1'b0, 4'd1, 16'h0007, 8'd1), "new_d0");
    step(1'b1, 4'd7, mk(1'b0, 1'b0, 4'd2, 16'h0077, 8'd1), "new_d1");
    step(1'b1, 4'd7, mk(1'b0, 1'b0, 4'd3, 16'h0777, 8'd1), "new_d2");
    step(1'b1, 4'd7, mk(1'b1, 1'b0, 4'd0, 16'h0000, 8'd0), "new_admit");
    admit_drain();
    rst = 1'b0;
    #1;
    expect_now(mk(1'b0, 1'b0, 4'd0, 16'h0000, 8'd0), "rst_after_prog");
    @(posedge clock);
    #1;
    rst = 1'b1;
    admit_seq(8'd0);
    admit_drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/password_lock_n.md
PASSWORD_LOCK_N -- requirements
Module: password_lock_n

Interface
REQ-001 Parameter DIGITS, default 4, number of digits in a password sequence (1..15).
REQ-002 Parameter DW, default 4, width of one digit in bits.
REQ-003 Parameter PASSWORD, default 16'h4321, reset password; digit k occupies bits [k*DW +: DW], digit 0 entered first.
REQ-004 Parameter MAX_FAIL, default 3, consecutive failed sequences that trigger lockout (1..255).
REQ-005 Parameter ADMIT_CYCLES, default 12, clock cycles admitted stays high.
REQ-006 Parameter LOCK_CYCLES, default 1000, clock cycles lockout lasts.
REQ-007 clock  input  1  system clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 confirm  input  1  single-cycle, already-debounced digit-entry strobe, active-high.
REQ-010 digit_in  input  DW  digit sampled on a confirm cycle.
REQ-011 admitted  output  1  high while in ADMIT.
REQ-012 locked  output  1  high while in LOCKOUT.
REQ-013 progress  output  4  digits accepted so far in the current sequence.
REQ-014 entered  output  DIGITS*DW  digits accepted so far, same packing as PASSWORD; unfilled slots zero.
REQ-015 fail_count  output  8  consecutive failed sequences.

Function
REQ-016 States: ENTRY, ADMIT, LOCKOUT (plus PROGRAM, see REQ-030); all outputs registered.
REQ-017 ENTRY: each confirm writes digit_in into slot progress of entered and increments progress the next cycle.
REQ-018 No per-digit abort: comparison happens only when the DIGITS-th digit is confirmed; full sequence = stored password -> match.
REQ-019 Match: next cycle state=ADMIT, admitted=1, fail_count=0, progress=0, entered cleared.
REQ-020 Mismatch with fail_count+1 < MAX_FAIL: next cycle fail_count increments, progress=0, entered cleared, state stays ENTRY.
REQ-021 Mismatch with fail_count+1 = MAX_FAIL: next cycle state=LOCKOUT, locked=1, fail_count=MAX_FAIL.
REQ-022 ADMIT lasts exactly ADMIT_CYCLES cycles, then ENTRY; confirm ignored in ADMIT unless REQ-030 applies.
REQ-023 LOCKOUT lasts exactly LOCK_CYCLES cycles, then ENTRY with fail_count=0; every confirm in LOCKOUT ignored.
REQ-024 Dwell counter sized for max(ADMIT_CYCLES, LOCK_CYCLES); fail_count saturates at 255.
REQ-025 Confirm held high N cycles counts as N entries (debounce is upstream).
REQ-026 Unreachable state encodings return to ENTRY on next edge.

Reset
REQ-027 rst low, at any time or state: state=ENTRY, admitted=0, locked=0, progress=0, entered=0, fail_count=0.
REQ-028 Reset mid-sequence, mid-ADMIT or mid-LOCKOUT discards all progress and timers; lockout not resumed.
REQ-029 Stored password reloads PASSWORD on reset.

Configuration
REQ-030 Macro PASSWORD_PROGRAM_EN defined: extra input prog_req (1 bit); confirm with prog_req=1 during ADMIT enters PROGRAM (progress=0, that digit not stored); next DIGITS confirms fill entered; on the DIGITS-th the sequence replaces the stored password, state=ENTRY, entered cleared.
REQ-031 In PROGRAM, admitted=1 and no ADMIT_CYCLES timeout applies; reset aborts programming and restores PASSWORD.
REQ-032 Macro undefined: no prog_req port, no PROGRAM state, password fixed at PASSWORD.

Verification
REQ-033 Defaults, confirms 1,2,3,4 -> admitted=1 the cycle after 4th confirm for 12 cycles; fail_count=0.
REQ-034 Confirms 1,9,3,4 -> no admit; progress stays 1,2,3 through digit 3; fail_count=1 after 4th.
REQ-035 Three wrong sequences -> locked=1 for 1000 cycles, confirms ignored, then fail_count=0 and 1,2,3,4 admits.
REQ-036 rst low after 2 correct digits -> progress=0, entered=0; subsequent 1,2,3,4 admits.
REQ-037 PASSWORD_PROGRAM_EN: admit, confirm with prog_req=1, enter 7,7,7,7 -> 1,2,3,4 fails, 7,7,7,7 admits; after rst 1,2,3,4 admits.
